// File: rtl/zmips_pkg.sv
// Shared definitions for the zmips multiply/divide unit: op codes, FSM states, default width.
package zmips_pkg;

    localparam int ZMIPS_XLEN = 32;

    typedef enum logic [1:0] {
        ZMIPS_MD_MULT  = 2'b00,
        ZMIPS_MD_MULTU = 2'b01,
        ZMIPS_MD_DIV   = 2'b10,
        ZMIPS_MD_DIVU  = 2'b11
    } zmips_md_op_e;

    typedef enum logic [1:0] {
        ZMIPS_MD_IDLE,
        ZMIPS_MD_MUL,
        ZMIPS_MD_DIV_ST,
        ZMIPS_MD_FIXUP
    } zmips_md_state_e;

endpackage

// File: rtl/zmips_muldiv_if.sv
// ID/EX-side bundle for the multiply/divide unit; master is the pipeline, slave is the unit.
interface zmips_muldiv_if
    import zmips_pkg::*;
#(
    parameter int W = ZMIPS_XLEN
);
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] rs_val;
    logic [W-1:0] rt_val;
    logic         mthi;
    logic         mtlo;
    logic         rd_hilo_req;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         busy;
    logic         done;
    logic         stall;

    modport master (
        output start, op, rs_val, rt_val, mthi, mtlo, rd_hilo_req,
        input  hi, lo, busy, done, stall
    );

    modport slave (
        input  start, op, rs_val, rt_val, mthi, mtlo, rd_hilo_req,
        output hi, lo, busy, done, stall
    );
endinterface

// File: rtl/zmips_muldiv_step.sv
// One combinational iteration: shift-add multiply step or restoring divide step.
module zmips_muldiv_step
    import zmips_pkg::*;
#(
    parameter int W = ZMIPS_XLEN
) (
    input  logic           mode_div,
    input  logic [2*W-1:0] acc,
    input  logic [W-1:0]   operand,
    output logic [2*W-1:0] acc_next
);
    logic [W-1:0] add_a;
    logic [W-1:0] add_b;
    logic         add_cin;
    logic [W-1:0] sum;
    logic         cout;

    // Divide subtracts the divisor from the shifted partial remainder; multiply adds the multiplicand.
    always_comb begin
        add_a   = acc[2*W-1:W];
        add_b   = '0;
        add_cin = 1'b0;
        if (mode_div) begin
            add_a   = acc[2*W-2:W-1];
            add_b   = ~operand;
            add_cin = 1'b1;
        end else if (acc[0]) begin
            add_b = operand;
        end
    end

    zmips_n_adder #(.W(W)) u_adder (
        .a    (add_a),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (sum),
        .cout (cout)
    );

    // The bit shifted out of the remainder counts toward the compare, so it forces a subtract.
    always_comb begin
        acc_next = '0;
        if (mode_div) begin
            if (acc[2*W-1] | cout) begin
                acc_next = {sum, acc[W-2:0], 1'b1};
            end else begin
                acc_next = {acc[2*W-2:0], 1'b0};
            end
        end else begin
            acc_next = {cout, sum, acc[W-1:1]};
        end
    end
endmodule

// File: rtl/zmips_n_adder.sv
// Plain W-bit ripple adder with carry in/out, used for both add and subtract.
module zmips_n_adder #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
endmodule

// File: rtl/zmips_muldiv.sv
// Iterative MIPS HI/LO multiply/divide unit, state updated on the falling clock edge.
// Define ZMIPS_FAST_MUL_EN to replace the iterative multiply with a single-cycle product.
module zmips_muldiv
    import zmips_pkg::*;
#(
    parameter int W = ZMIPS_XLEN
) (
    input logic             clk,
    input logic             rst,
    zmips_muldiv_if.slave   md
);
    localparam int CW = $clog2(W);

    zmips_md_state_e state, state_next;
    logic [CW-1:0]   counter;
    logic [2*W-1:0]  acc;
    logic [2*W-1:0]  acc_step;
    logic [W-1:0]    operand;
    logic [W-1:0]    dividend_raw;
    logic            op_div;
    logic            res_neg;
    logic            rem_neg;
    logic            div_zero;
    logic            done_q;
    logic [W-1:0]    hi_q;
    logic [W-1:0]    lo_q;
    logic            is_signed;
    logic            is_div;
    logic [W-1:0]    mag_a;
    logic [W-1:0]    mag_b;
    logic [2*W-1:0]  prod;
    logic [W-1:0]    quot;
    logic [W-1:0]    rem;

    always_comb begin
        is_signed = (md.op == ZMIPS_MD_MULT) || (md.op == ZMIPS_MD_DIV);
        is_div    = (md.op == ZMIPS_MD_DIV)  || (md.op == ZMIPS_MD_DIVU);
        mag_a     = (is_signed && md.rs_val[W-1]) ? -md.rs_val : md.rs_val;
        mag_b     = (is_signed && md.rt_val[W-1]) ? -md.rt_val : md.rt_val;
        prod      = res_neg ? -acc : acc;
        quot      = res_neg ? -acc[W-1:0] : acc[W-1:0];
        rem       = rem_neg ? -acc[2*W-1:W] : acc[2*W-1:W];
    end

    zmips_muldiv_step #(.W(W)) u_step (
        .mode_div (state == ZMIPS_MD_DIV_ST),
        .acc      (acc),
        .operand  (operand),
        .acc_next (acc_step)
    );

    always_ff @(negedge clk) begin
        if (rst) begin
            state <= ZMIPS_MD_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ZMIPS_MD_IDLE: begin
                if (md.start) begin
`ifdef ZMIPS_FAST_MUL_EN
                    state_next = is_div ? ZMIPS_MD_DIV_ST : ZMIPS_MD_FIXUP;
`else
                    state_next = is_div ? ZMIPS_MD_DIV_ST : ZMIPS_MD_MUL;
`endif
                end
            end
            ZMIPS_MD_MUL, ZMIPS_MD_DIV_ST: begin
                if (counter == '0) state_next = ZMIPS_MD_FIXUP;
            end
            ZMIPS_MD_FIXUP: state_next = ZMIPS_MD_IDLE;
            default:        state_next = ZMIPS_MD_IDLE;
        endcase
    end

    // Datapath: latch magnitudes on start, iterate, then sign-correct and commit HI/LO in FIXUP.
    always_ff @(negedge clk) begin
        if (rst) begin
            counter      <= '0;
            acc          <= '0;
            operand      <= '0;
            dividend_raw <= '0;
            op_div       <= 1'b0;
            res_neg      <= 1'b0;
            rem_neg      <= 1'b0;
            div_zero     <= 1'b0;
            done_q       <= 1'b0;
            hi_q         <= '0;
            lo_q         <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ZMIPS_MD_IDLE: begin
                    if (md.start) begin
                        counter      <= CW'(W - 1);
                        op_div       <= is_div;
                        res_neg      <= is_signed & (md.rs_val[W-1] ^ md.rt_val[W-1]);
                        rem_neg      <= is_signed & md.rs_val[W-1];
                        div_zero     <= is_div & (md.rt_val == '0);
                        dividend_raw <= md.rs_val;
                        if (is_div) begin
                            acc     <= {{W{1'b0}}, mag_a};
                            operand <= mag_b;
                        end else begin
`ifdef ZMIPS_FAST_MUL_EN
                            acc     <= {{W{1'b0}}, mag_a} * {{W{1'b0}}, mag_b};
`else
                            acc     <= {{W{1'b0}}, mag_b};
`endif
                            operand <= mag_a;
                        end
                    end else begin
                        if (md.mthi) hi_q <= md.rs_val;
                        if (md.mtlo) lo_q <= md.rs_val;
                    end
                end
                ZMIPS_MD_MUL, ZMIPS_MD_DIV_ST: begin
                    acc     <= acc_step;
                    counter <= counter - CW'(1);
                end
                ZMIPS_MD_FIXUP: begin
                    done_q <= 1'b1;
                    if (!op_div) begin
                        hi_q <= prod[2*W-1:W];
                        lo_q <= prod[W-1:0];
                    end else if (div_zero) begin
                        hi_q <= dividend_raw;
                        lo_q <= '1;
                    end else begin
                        hi_q <= rem;
                        lo_q <= quot;
                    end
                end
                default: ;
            endcase
        end
    end

    assign md.hi    = hi_q;
    assign md.lo    = lo_q;
    assign md.busy  = (state != ZMIPS_MD_IDLE);
    assign md.done  = done_q;
    assign md.stall = md.busy & (md.start | md.rd_hilo_req | md.mthi | md.mtlo);
endmodule

// File: tb/tb_zmips_muldiv.sv
// Directed bench for zmips_muldiv: expected HI/LO from a behavioural model, queued at start, checked at done.
module tb_zmips_muldiv;
    import zmips_pkg::*;

    localparam int W = ZMIPS_XLEN;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    zmips_muldiv_if #(.W(W)) md ();

    zmips_muldiv #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .md  (md.slave)
    );

    function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t            e;
        longint          sa;
        longint          sbv;
        longint unsigned ua;
        longint unsigned ub;
        logic [63:0]     p;
        sa  = $signed(a);
        sbv = $signed(b);
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        e.hi = '0;
        e.lo = '0;
        case (op)
            2'b00: begin p = sa * sbv; e.hi = p[63:32]; e.lo = p[31:0]; end
            2'b01: begin p = ua * ub;  e.hi = p[63:32]; e.lo = p[31:0]; end
            2'b10: begin
                if (b == 32'd0) begin e.hi = a; e.lo = '1; end
                else begin p = sa / sbv; e.lo = p[31:0]; p = sa % sbv; e.hi = p[31:0]; end
            end
            default: begin
                if (b == 32'd0) begin e.hi = a; e.lo = '1; end
                else begin p = ua / ub; e.lo = p[31:0]; p = ua % ub; e.hi = p[31:0]; end
            end
        endcase
        return e;
    endfunction

    function automatic int expBusy(input logic [1:0] op);
`ifdef ZMIPS_FAST_MUL_EN
        return op[1] ? (W + 1) : 1;
`else
        return (op == 2'b00) ? (W + 1) : (W + 1);
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk);
        #1;
        md.start  = 1'b1;
        md.op     = op;
        md.rs_val = a;
        md.rt_val = b;
        sb_q.push_back(model(op, a, b));
    endtask

    // Launch one operation and follow it to its done pulse, optionally poking the unit while busy.
    task automatic runOp(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input bit rd_req, input bit disturb);
        int          n;
        exp_t        e;
        logic [31:0] hi_prev;
        hi_prev = md.hi;
        applyStimulus(op, a, b);
        @(posedge clk);
        #1;
        md.start       = 1'b0;
        md.rd_hilo_req = rd_req;
        n = 0;
        while (md.busy === 1'b1 && n < 200) begin
            n++;
            if (disturb && n == 5) begin
                md.start  = 1'b1;
                md.op     = 2'b00;
                md.rs_val = 32'h0000_1234;
                md.rt_val = 32'h0000_0005;
                md.mthi   = 1'b1;
                #1;
                checkOutput({tag, "_stall_disturb"}, {31'd0, md.stall}, 32'd1);
            end
            if (disturb && n == 6) begin
                md.start = 1'b0;
                md.mthi  = 1'b0;
            end
            if (rd_req) checkOutput({tag, "_stall_rd"}, {31'd0, md.stall}, 32'd1);
            if (disturb) checkOutput({tag, "_hi_hold"}, md.hi, hi_prev);
            @(posedge clk);
            #1;
        end
        checkOutput({tag, "_busy_cycles"}, n, expBusy(op));
        checkOutput({tag, "_done"}, {31'd0, md.done}, 32'd1);
        if (rd_req) checkOutput({tag, "_stall_idle"}, {31'd0, md.stall}, 32'd0);
        if (sb_q.size() == 0) begin
            checkOutput({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            checkOutput({tag, "_hi"}, md.hi, e.hi);
            checkOutput({tag, "_lo"}, md.lo, e.lo);
        end
        md.rd_hilo_req = 1'b0;
        @(posedge clk);
        #1;
        checkOutput({tag, "_done_pulse"}, {31'd0, md.done}, 32'd0);
    endtask

    initial begin
        int n;
        bit done_seen;
        md.start       = 1'b0;
        md.op          = 2'b00;
        md.rs_val      = '0;
        md.rt_val      = '0;
        md.mthi        = 1'b0;
        md.mtlo        = 1'b0;
        md.rd_hilo_req = 1'b0;
        rst            = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("rst_hi",    md.hi, 32'd0);
        checkOutput("rst_lo",    md.lo, 32'd0);
        checkOutput("rst_busy",  {31'd0, md.busy}, 32'd0);
        checkOutput("rst_done",  {31'd0, md.done}, 32'd0);
        checkOutput("rst_stall", {31'd0, md.stall}, 32'd0);

        runOp("mult_neg",  2'b00, 32'd7,          32'hFFFF_FFFD, 1'b0, 1'b0);
        runOp("multu_max", 2'b01, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 1'b1, 1'b0);
        runOp("div_neg",   2'b10, 32'hFFFF_FFF9,  32'd2,         1'b0, 1'b0);
        runOp("divu_zero", 2'b11, 32'd7,          32'd0,         1'b0, 1'b0);
        runOp("div_ovf",   2'b10, 32'h8000_0000,  32'hFFFF_FFFF, 1'b0, 1'b0);
        runOp("div_zero_s",2'b10, 32'hFFFF_FF00,  32'd0,         1'b0, 1'b0);
        runOp("mult_mix",  2'b00, 32'h8000_0000,  32'h8000_0000, 1'b0, 1'b0);
        runOp("divu_dist", 2'b11, 32'hDEAD_BEEF,  32'h0000_1001, 1'b1, 1'b1);
        runOp("div_remneg",2'b10, 32'h8000_0001,  32'h0000_0007, 1'b0, 1'b0);

        // Idle mtlo/mthi write straight into LO/HI without a done pulse.
        @(posedge clk);
        #1;
        md.mtlo   = 1'b1;
        md.rs_val = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        md.mtlo = 1'b0;
        checkOutput("mtlo_lo",   md.lo, 32'hCAFE_F00D);
        checkOutput("mtlo_done", {31'd0, md.done}, 32'd0);
        md.mthi   = 1'b1;
        md.rs_val = 32'h0BAD_CAFE;
        @(posedge clk);
        #1;
        md.mthi = 1'b0;
        checkOutput("mthi_hi", md.hi, 32'h0BAD_CAFE);

        // Start beats a simultaneous mtlo in idle.
        md.mtlo = 1'b1;
        runOp("start_wins", 2'b11, 32'd100, 32'd9, 1'b0, 1'b0);
        md.mtlo = 1'b0;

        // Abort an operation mid-flight with reset.
        @(posedge clk);
        #1;
        md.start  = 1'b1;
        md.op     = 2'b11;
        md.rs_val = 32'd12345;
        md.rt_val = 32'd17;
        @(posedge clk);
        #1;
        md.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        checkOutput("abort_busy_before", {31'd0, md.busy}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("abort_busy", {31'd0, md.busy}, 32'd0);
        checkOutput("abort_hi",   md.hi, 32'd0);
        checkOutput("abort_lo",   md.lo, 32'd0);
        done_seen = 1'b0;
        for (n = 0; n < 40; n++) begin
            @(posedge clk);
            #1;
            if (md.done === 1'b1) done_seen = 1'b1;
        end
        checkOutput("abort_no_done", {31'd0, done_seen}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/zmips_muldiv.md
Name: zmips_muldiv

Overview:
- Iterative multiply/divide unit in the EX stage, directly downstream of the ID stage's register-file read.
- Consumes the rs/rt operand values and decoded mult/div opcode from the ID/EX boundary.
- Owns the architectural HI/LO registers and serves MFHI/MFLO/MTHI/MTLO.
- Raises a stall request so the pipeline freezes ID when an instruction needs the unit while it is busy.

Parameters:
W, 32, operand width; HI and LO are each W bits; iteration count = W.

Ports:
clk  in  1  pipeline clock; all state updates on falling edge, same as the rest of the pipeline
rst  in  1  synchronous, active-high reset
start  in  1  launch operation in op using rs_val/rt_val
op  in  2  00=MULT, 01=MULTU, 10=DIV, 11=DIVU
rs_val  in  W  multiplicand / dividend
rt_val  in  W  multiplier / divisor
mthi  in  1  write rs_val to HI
mtlo  in  1  write rs_val to LO
rd_hilo_req  in  1  ID holds an MFHI/MFLO
hi  out  W  HI register
lo  out  W  LO register
busy  out  1  operation in progress
done  out  1  one-cycle pulse: HI/LO just updated by an operation
stall  out  1  busy & (start | rd_hilo_req | mthi | mtlo)

Behaviour:
- Reset: state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0. Reset mid-operation aborts; HI/LO are zeroed and no done pulse is produced.
- FSM states: IDLE, MUL, DIV, FIXUP.
- IDLE + start at an edge:
  - Latch operand magnitudes. Signed ops take the two's-complement absolute value; unsigned ops take raw values.
  - Record result signs.
  - counter=W-1.
  - Go to MUL (op[1]=0) or DIV (op[1]=1).
- MUL: radix-2 shift-add, one multiplier bit per edge, 2W-bit accumulator.
- DIV: restoring shift-subtract, one quotient bit per edge.
- Counter handling (MUL and DIV): counter decrements each edge; at counter==0, go to FIXUP.
- FIXUP, one edge:
  - Apply sign: product negated if signs differ; quotient negated if signs differ; remainder takes the dividend's sign.
  - Write HI/LO: MUL gives HI=product[2W-1:W], LO=product[W-1:0]; DIV gives LO=quotient, HI=remainder.
  - Go to IDLE; done=1 for the following cycle.
- Latency: start edge + W compute edges + 1 FIXUP edge. busy is high for W+1 cycles (33 at W=32); done is high in the first cycle busy is low.
- busy = (state != IDLE).
- start, mthi, mtlo while busy: ignored; stall is asserted so ID re-presents the instruction.
- IDLE with start and mthi/mtlo in the same cycle: start wins; mthi/mtlo ignored.
- IDLE with mthi or mtlo: register written at the next edge; done not asserted.
- Divide by zero (signed or unsigned): same latency; HI=rs_val (dividend), LO=all ones.
- Signed overflow, DIV 0x80000000 / -1: LO=0x80000000, HI=0. This falls out of the magnitude arithmetic modulo 2^W.
- hi/lo hold their previous values throughout an operation until the FIXUP edge.

Optional Feature:
ZMIPS_FAST_MUL_EN:
- Defined:
  - MULT/MULTU use a single-cycle combinational W×W product.
  - Start edge goes directly to FIXUP; busy high 1 cycle, done 1 cycle later.
  - DIV/DIVU unchanged.
- Undefined: iterative multiply as described above; no combinational multiplier is inferred.

Decomposition:
- Shared package zmips_pkg:
  - op encodings ZMIPS_MD_MULT/MULTU/DIV/DIVU;
  - FSM state encodings;
  - default width ZMIPS_XLEN=32.
- Sub-module zmips_muldiv_step: combinational single iteration.
  - Shift-add for MUL, shift-compare-subtract for DIV, selected by a mode bit.
  - Builds on zmips_n_adder for the W-bit add/subtract.

Test Plan:
- MULT rs=7, rt=0xFFFFFFFD: busy 33 cycles, then done=1, HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF: HI=0xFFFFFFFE, LO=0x00000001.
- DIV rs=0xFFFFFFF9 (-7), rt=2: LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU rs=7, rt=0: HI=7, LO=0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- During an operation:
  - rd_hilo_req=1: stall=1 every busy cycle, 0 once busy falls.
  - mthi=1 with rs_val=0x1234: stall=1, HI unaffected.
  - start with different operands: ignored; final result matches the first operation.
- Idle: mtlo rs_val=0xCAFEF00D → next edge LO=0xCAFEF00D, done=0.
- Reset mid-operation: rst at compute iteration 10 → next edge busy=0, hi=lo=0; no done pulse follows.
